instr_fetch_unit: RTL and testbench

- Front-end stage directly upstream of the main decoder.
- Holds the PC and issues word fetches to instruction memory over a valid/ready request channel, with in-order responses.
- Buffers returned instructions with their PCs in a small FIFO and presents them to decode with a valid/ready handshake; instr[6:0] drives the decoder opcode input.
- Accepts redirects (taken branch / jal) from execute, flushing buffered and in-flight wrong-path instructions.

---
 rtl/instr_fetch_unit.sv | 138 +++++++++++++
 tb/tb_instr_fetch_unit.sv | 407 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: holds the PC, issues word fetches to instruction memory over a
// valid/ready request channel, pairs in-order responses with their PCs and buffers them in a
// small FIFO for the decoder. Redirects from execute flush the buffer and mark every fetch
// still in flight to be dropped on return.
//
// Ports:
//   clk, rst          clock and synchronous active-high reset
//   imem_req_*        fetch request channel (valid/ready, address = current PC)
//   imem_rsp_*        in-order fetch responses, no backpressure
//   redirect_*        PC redirect from execute (taken branch / jal)
//   instr_valid/ready decode handshake for the buffered head instruction
//   instr, instr_pc   head instruction and its PC
//   opcode            instr[6:0], feeds the decoder opcode input
module instr_fetch_unit #(
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int unsigned     DEPTH    = 2
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [31:0]     instr,
    output logic [XLEN-1:0] instr_pc,
    output logic [6:0]      opcode
);

    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntW = $clog2(DEPTH + 1);
    // One extra bit so outstanding + occupancy (up to 2*DEPTH) cannot overflow.
    localparam logic [CntW:0] DepthSum = (CntW + 1)'(DEPTH);

    // State
    logic [XLEN-1:0] pc_q, pc_d;
    logic [CntW-1:0] outstanding_q, outstanding_d;
    logic [CntW-1:0] drop_q, drop_d;
    logic [CntW-1:0] count_q, count_d;
    logic [PtrW-1:0] pend_wr_q, pend_wr_d, pend_rd_q, pend_rd_d;
    logic [PtrW-1:0] fifo_wr_q, fifo_wr_d, fifo_rd_q, fifo_rd_d;

    logic [XLEN-1:0] pend_mem  [DEPTH];
    logic [XLEN-1:0] fifo_pc   [DEPTH];
    logic [31:0]     fifo_data [DEPTH];

    logic credit_ok;
    logic req_fire;
    logic rsp_fire;
    logic fifo_push;
    logic fifo_pop;

    // Redirect targets are word aligned; the low bits are ignored.
    logic unused_redirect_low;
    assign unused_redirect_low = ^redirect_pc[1:0];

    // Outputs
    assign credit_ok      = ({1'b0, outstanding_q} + {1'b0, count_q}) < DepthSum;
    assign imem_req_valid = !rst && credit_ok;
    assign imem_req_addr  = rst ? RESET_PC : pc_q;
    assign instr_valid    = !rst && (count_q != '0);
    assign instr          = fifo_data[fifo_rd_q];
    assign instr_pc       = fifo_pc[fifo_rd_q];
    assign opcode         = instr[6:0];

    assign req_fire  = imem_req_valid && imem_req_ready;
    assign rsp_fire  = imem_rsp_valid && !rst;
    // Responses are dropped while wrong-path fetches drain or in a redirect cycle.
    assign fifo_push = rsp_fire && (drop_q == '0) && !redirect_valid;
    assign fifo_pop  = instr_valid && instr_ready;

    // Next-state logic
    always_comb begin
        pc_d          = pc_q;
        outstanding_d = outstanding_q + CntW'(req_fire) - CntW'(rsp_fire);
        drop_d        = drop_q;
        count_d       = count_q + CntW'(fifo_push) - CntW'(fifo_pop);
        pend_wr_d     = pend_wr_q + PtrW'(req_fire);
        pend_rd_d     = pend_rd_q + PtrW'(rsp_fire);
        fifo_wr_d     = fifo_wr_q + PtrW'(fifo_push);
        fifo_rd_d     = fifo_rd_q + PtrW'(fifo_pop);

        if (req_fire) begin
            pc_d = pc_q + XLEN'(4);
        end
        if (rsp_fire && (drop_q != '0)) begin
            drop_d = drop_q - CntW'(1);
        end

        if (redirect_valid) begin
            pc_d      = {redirect_pc[XLEN-1:2], 2'b00};
            // Everything still in flight after this cycle belongs to the old path.
            drop_d    = outstanding_d;
            count_d   = '0;
            fifo_wr_d = '0;
            fifo_rd_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q          <= RESET_PC;
            outstanding_q <= '0;
            drop_q        <= '0;
            count_q       <= '0;
            pend_wr_q     <= '0;
            pend_rd_q     <= '0;
            fifo_wr_q     <= '0;
            fifo_rd_q     <= '0;
        end else begin
            pc_q          <= pc_d;
            outstanding_q <= outstanding_d;
            drop_q        <= drop_d;
            count_q       <= count_d;
            pend_wr_q     <= pend_wr_d;
            pend_rd_q     <= pend_rd_d;
            fifo_wr_q     <= fifo_wr_d;
            fifo_rd_q     <= fifo_rd_d;
        end
    end

    // Storage arrays need no reset; pointers and counts define validity.
    always_ff @(posedge clk) begin
        if (req_fire) begin
            pend_mem[pend_wr_q] <= pc_q;
        end
        if (fifo_push) begin
            fifo_data[fifo_wr_q] <= imem_rsp_data;
            fifo_pc[fifo_wr_q]   <= pend_mem[pend_rd_q];
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with an in-order memory model of configurable latency.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic [6:0]  opcode;

    always #5 clk = ~clk;

    instr_fetch_unit #(
        .XLEN     (32),
        .RESET_PC (32'h0),
        .DEPTH    (2)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .opcode         (opcode)
    );

    typedef struct packed {
        logic [31:0] addr;
        int          due;
    } mem_ent_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] data;
        logic [6:0]  op;
    } rcv_t;

    mem_ent_t    mem_q[$];
    rcv_t        rcv[$];
    logic [31:0] hs_log[$];
    int          lat;
    int          cyc;
    int          n_checks;
    int          n_errors;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h0000_0013;
    endfunction

    // One clock cycle: record handshakes before the edge, then drive the memory response
    // for the next cycle after the falling edge.
    task automatic tick();
        logic        hs;
        logic [31:0] hs_addr;
        #1;
        hs      = imem_req_valid && imem_req_ready;
        hs_addr = imem_req_addr;
        if (instr_valid && instr_ready) begin
            rcv.push_back('{pc: instr_pc, data: instr, op: opcode});
        end
        @(posedge clk);
        cyc++;
        if (rst) begin
            mem_q.delete();
        end else if (hs) begin
            mem_q.push_back('{addr: hs_addr, due: cyc + lat - 1});
            hs_log.push_back(hs_addr);
        end
        @(negedge clk);
        if (!rst && mem_q.size() > 0 && mem_q[0].due <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_word(mem_q[0].addr);
            void'(mem_q.pop_front());
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = '0;
        end
        #1;
    endtask

    task automatic do_reset();
        rst            = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        instr_ready    = 1'b0;
        imem_req_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        rcv.delete();
        hs_log.delete();
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        n_checks++;
        if (imem_req_valid !== 1'b0) begin
            n_errors++; $display("FAIL reset_req_valid: got %b want 0", imem_req_valid);
        end
        n_checks++;
        if (instr_valid !== 1'b0) begin
            n_errors++; $display("FAIL reset_instr_valid: got %b want 0", instr_valid);
        end
        n_checks++;
        if (imem_req_addr !== 32'h0) begin
            n_errors++; $display("FAIL reset_addr: got %h want 00000000", imem_req_addr);
        end
    endtask

    task automatic test_stream();
        logic [31:0] exp;
        do_reset();
        lat = 1;
        n_checks++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin
            n_errors++;
            $display("FAIL stream_first_req: got v=%b a=%h want v=1 a=0",
                     imem_req_valid, imem_req_addr);
        end
        imem_req_ready = 1'b1;
        instr_ready    = 1'b1;
        repeat (20) tick();
        n_checks++;
        if (rcv.size() < 8 || hs_log.size() < 8) begin
            n_errors++;
            $display("FAIL stream_count: got rcv=%0d req=%0d want >=8", rcv.size(), hs_log.size());
        end
        for (int i = 0; i < 8 && i < rcv.size() && i < hs_log.size(); i++) begin
            exp = mem_word(32'(4 * i));
            n_checks++;
            if (hs_log[i] !== 32'(4 * i)) begin
                n_errors++; $display("FAIL stream_req_addr[%0d]: got %h want %h", i, hs_log[i], 4 * i);
            end
            n_checks++;
            if (rcv[i].pc !== 32'(4 * i) || rcv[i].data !== exp || rcv[i].op !== exp[6:0]) begin
                n_errors++;
                $display("FAIL stream_instr[%0d]: got pc=%h d=%h op=%h want pc=%h d=%h op=%h",
                         i, rcv[i].pc, rcv[i].data, rcv[i].op, 4 * i, exp, exp[6:0]);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] exp0;
        exp0 = mem_word(32'h0);
        do_reset();
        lat            = 1;
        imem_req_ready = 1'b1;
        instr_ready    = 1'b0;
        for (int t = 0; t < 10; t++) begin
            tick();
            if (t >= 2) begin
                n_checks++;
                if (instr_valid !== 1'b1 || instr_pc !== 32'h0 || instr !== exp0) begin
                    n_errors++;
                    $display("FAIL bp_head_stable[%0d]: got v=%b pc=%h i=%h want v=1 pc=0 i=%h",
                             t, instr_valid, instr_pc, instr, exp0);
                end
            end
        end
        n_checks++;
        if (hs_log.size() != 2) begin
            n_errors++; $display("FAIL bp_req_count: got %0d want 2", hs_log.size());
        end
        n_checks++;
        if (imem_req_valid !== 1'b0) begin
            n_errors++; $display("FAIL bp_req_valid: got %b want 0", imem_req_valid);
        end
        instr_ready = 1'b1;
        repeat (12) tick();
        n_checks++;
        if (rcv.size() < 4) begin
            n_errors++; $display("FAIL bp_drain_count: got %0d want >=4", rcv.size());
        end
        for (int i = 0; i < 4 && i < rcv.size(); i++) begin
            n_checks++;
            if (rcv[i].pc !== 32'(4 * i)) begin
                n_errors++; $display("FAIL bp_drain_pc[%0d]: got %h want %h", i, rcv[i].pc, 4 * i);
            end
        end
    endtask

    task automatic test_toggle();
        do_reset();
        lat         = 1;
        instr_ready = 1'b1;
        for (int t = 0; t < 30; t++) begin
            imem_req_ready = ((t % 2) == 0);
            tick();
        end
        imem_req_ready = 1'b0;
        n_checks++;
        if (hs_log.size() < 8 || rcv.size() < 6) begin
            n_errors++;
            $display("FAIL toggle_count: got req=%0d rcv=%0d want >=8,>=6", hs_log.size(), rcv.size());
        end
        for (int i = 0; i < 8 && i < hs_log.size(); i++) begin
            n_checks++;
            if (hs_log[i] !== 32'(4 * i)) begin
                n_errors++; $display("FAIL toggle_req_addr[%0d]: got %h want %h", i, hs_log[i], 4 * i);
            end
        end
        for (int i = 0; i < 6 && i < rcv.size(); i++) begin
            n_checks++;
            if (rcv[i].pc !== 32'(4 * i)) begin
                n_errors++; $display("FAIL toggle_pc[%0d]: got %h want %h", i, rcv[i].pc, 4 * i);
            end
        end
    endtask

    task automatic test_redirect_drop();
        logic [31:0] exp;
        do_reset();
        lat            = 3;
        imem_req_ready = 1'b1;
        instr_ready    = 1'b1;
        tick();
        tick();
        n_checks++;
        if (hs_log.size() != 2 || imem_req_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL rd_outstanding: got req=%0d v=%b want 2, 0", hs_log.size(), imem_req_valid);
        end
        redirect_valid = 1'b1;
        redirect_pc    = 32'h103;
        tick();
        redirect_valid = 1'b0;
        n_checks++;
        if (imem_req_addr !== 32'h100) begin
            n_errors++; $display("FAIL rd_addr: got %h want 00000100", imem_req_addr);
        end
        repeat (16) tick();
        n_checks++;
        if (rcv.size() < 2 || hs_log.size() < 3) begin
            n_errors++;
            $display("FAIL rd_count: got rcv=%0d req=%0d want >=2,>=3", rcv.size(), hs_log.size());
        end
        if (hs_log.size() >= 3) begin
            n_checks++;
            if (hs_log[2] !== 32'h100) begin
                n_errors++; $display("FAIL rd_next_req: got %h want 00000100", hs_log[2]);
            end
        end
        if (rcv.size() >= 2) begin
            exp = mem_word(32'h100);
            n_checks++;
            if (rcv[0].pc !== 32'h100 || rcv[0].data !== exp) begin
                n_errors++;
                $display("FAIL rd_first_instr: got pc=%h d=%h want pc=00000100 d=%h",
                         rcv[0].pc, rcv[0].data, exp);
            end
            n_checks++;
            if (rcv[1].pc !== 32'h104) begin
                n_errors++; $display("FAIL rd_second_pc: got %h want 00000104", rcv[1].pc);
            end
        end
    endtask

    task automatic test_redirect_b2b();
        do_reset();
        lat            = 2;
        imem_req_ready = 1'b1;
        instr_ready    = 1'b1;
        tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h80;
        tick();
        redirect_pc = 32'h200;
        tick();
        redirect_valid = 1'b0;
        n_checks++;
        if (imem_req_addr !== 32'h200) begin
            n_errors++; $display("FAIL b2b_addr: got %h want 00000200", imem_req_addr);
        end
        n_checks++;
        if (hs_log.size() != 2 || hs_log[1] !== 32'h4) begin
            n_errors++;
            $display("FAIL b2b_redirect_cycle_req: got n=%0d a1=%h want n=2 a1=00000004",
                     hs_log.size(), hs_log[1]);
        end
        repeat (16) tick();
        n_checks++;
        if (rcv.size() < 2) begin
            n_errors++; $display("FAIL b2b_count: got %0d want >=2", rcv.size());
        end
        for (int i = 0; i < rcv.size(); i++) begin
            n_checks++;
            if (rcv[i].pc !== 32'(32'h200 + 4 * i)) begin
                n_errors++;
                $display("FAIL b2b_pc[%0d]: got %h want %h", i, rcv[i].pc, 32'h200 + 4 * i);
            end
        end
    endtask

    task automatic test_wrap();
        do_reset();
        lat            = 1;
        imem_req_ready = 1'b0;
        instr_ready    = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFE;
        tick();
        redirect_valid = 1'b0;
        n_checks++;
        if (imem_req_addr !== 32'hFFFF_FFFC) begin
            n_errors++; $display("FAIL wrap_aligned: got %h want fffffffc", imem_req_addr);
        end
        imem_req_ready = 1'b1;
        tick();
        n_checks++;
        if (imem_req_addr !== 32'h0) begin
            n_errors++; $display("FAIL wrap_next_addr: got %h want 00000000", imem_req_addr);
        end
        repeat (10) tick();
        n_checks++;
        if (rcv.size() < 3) begin
            n_errors++; $display("FAIL wrap_count: got %0d want >=3", rcv.size());
        end else begin
            n_checks++;
            if (rcv[0].pc !== 32'hFFFF_FFFC || rcv[1].pc !== 32'h0 || rcv[2].pc !== 32'h4) begin
                n_errors++;
                $display("FAIL wrap_pcs: got %h %h %h want fffffffc 00000000 00000004",
                         rcv[0].pc, rcv[1].pc, rcv[2].pc);
            end
        end
    endtask

    task automatic test_mid_reset();
        do_reset();
        lat            = 1;
        imem_req_ready = 1'b1;
        instr_ready    = 1'b1;
        repeat (6) tick();
        n_checks++;
        if (instr_valid !== 1'b1 || imem_req_addr !== 32'h10) begin
            n_errors++;
            $display("FAIL mr_before: got v=%b a=%h want v=1 a=00000010", instr_valid, imem_req_addr);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        n_checks++;
        if (instr_valid !== 1'b0 || imem_req_addr !== 32'h0 || imem_req_valid !== 1'b1) begin
            n_errors++;
            $display("FAIL mr_after: got v=%b a=%h rv=%b want v=0 a=00000000 rv=1",
                     instr_valid, imem_req_addr, imem_req_valid);
        end
        rcv.delete();
        hs_log.delete();
        repeat (10) tick();
        n_checks++;
        if (rcv.size() < 2) begin
            n_errors++; $display("FAIL mr_count: got %0d want >=2", rcv.size());
        end else begin
            n_checks++;
            if (rcv[0].pc !== 32'h0 || rcv[1].pc !== 32'h4) begin
                n_errors++;
                $display("FAIL mr_restart: got %h %h want 00000000 00000004", rcv[0].pc, rcv[1].pc);
            end
        end
    endtask

    initial begin
        n_checks       = 0;
        n_errors       = 0;
        cyc            = 0;
        lat            = 1;
        rst            = 1'b1;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        instr_ready    = 1'b0;
        @(negedge clk);
        #1;
        test_reset();
        test_stream();
        test_backpressure();
        test_toggle();
        test_redirect_drop();
        test_redirect_b2b();
        test_wrap();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
